// File: rtl/rex_game_pkg.sv
// Shared types and constants for the Rex-Runner game core.
// Holds the game state encoding, coordinate type and jump height table.
package rex_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int unsigned COORD_W_DEF = 16;
  localparam int unsigned JUMP_LEN    = 8;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  // Height above ground for each jump tick; the last entry lands the dino.
  function automatic coord_t jump_y(input logic [2:0] idx);
    case (idx)
      3'd0:    jump_y = coord_t'(15);
      3'd1:    jump_y = coord_t'(27);
      3'd2:    jump_y = coord_t'(34);
      3'd3:    jump_y = coord_t'(36);
      3'd4:    jump_y = coord_t'(34);
      3'd5:    jump_y = coord_t'(27);
      3'd6:    jump_y = coord_t'(15);
      default: jump_y = '0;
    endcase
  endfunction

endpackage

// File: rtl/rex_obst_slots.sv
// Obstacle slot array: per-tick scrolling, spawn allocation with gap timer,
// and per-slot horizontal overlap with the dino column.
module rex_obst_slots
  import rex_game_pkg::*;
#(
  parameter int unsigned N_OBST   = 3,
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned SPAWN_X  = 232,
  parameter int unsigned DINO_X   = 16,
  parameter int unsigned DINO_W   = 16,
  parameter int unsigned OBST_W   = 16,
  parameter int unsigned GAP_MIN  = 24,
  parameter int unsigned GAP_MASK = 15
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_clear,
  input  logic                        i_step,
  input  logic [3:0]                  i_speed,
  input  logic [15:0]                 i_rand,
  output logic [N_OBST*COORD_W-1:0]   o_x,
  output logic [N_OBST-1:0]           o_valid,
  output logic [N_OBST-1:0]           o_overlap
);

  logic [COORD_W-1:0] r_x [N_OBST];
  logic [COORD_W-1:0] w_x_nx [N_OBST];
  logic [N_OBST-1:0]  r_valid, w_valid_nx;
  logic [COORD_W-1:0] r_gap, w_gap_nx;
  logic [COORD_W-1:0] w_speed;
  logic               w_spawned;

  always_comb begin
    w_speed    = COORD_W'(i_speed);
    w_x_nx     = r_x;
    w_valid_nx = r_valid;
    w_gap_nx   = r_gap;
    w_spawned  = 1'b0;
    if (i_clear) begin
      for (int unsigned i = 0; i < N_OBST; i++) w_x_nx[i] = '0;
      w_valid_nx = '0;
      w_gap_nx   = COORD_W'(GAP_MIN);
    end else if (i_step) begin
      // Moving first lets a slot that leaves the screen this tick take the new spawn.
      for (int unsigned i = 0; i < N_OBST; i++) begin
        if (r_valid[i]) begin
          if (r_x[i] < w_speed) w_valid_nx[i] = 1'b0;
          else                  w_x_nx[i]     = r_x[i] - w_speed;
        end
      end
      if (r_gap != '0) begin
        w_gap_nx = r_gap - 1'b1;
      end else begin
        for (int unsigned i = 0; i < N_OBST; i++) begin
          if (!w_spawned && !w_valid_nx[i]) begin
            w_x_nx[i]     = COORD_W'(SPAWN_X);
            w_valid_nx[i] = 1'b1;
            w_spawned     = 1'b1;
            w_gap_nx      = COORD_W'(GAP_MIN) + (COORD_W'(i_rand) & COORD_W'(GAP_MASK));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N_OBST; i++) r_x[i] <= '0;
      r_valid <= '0;
      r_gap   <= COORD_W'(GAP_MIN);
    end else begin
      r_x     <= w_x_nx;
      r_valid <= w_valid_nx;
      r_gap   <= w_gap_nx;
    end
  end

  always_comb begin
    o_x       = '0;
    o_overlap = '0;
    for (int unsigned i = 0; i < N_OBST; i++) begin
      o_x[i*COORD_W +: COORD_W] = r_x[i];
      o_overlap[i] = r_valid[i]
                  && (r_x[i] < COORD_W'(DINO_X + DINO_W))
                  && (({1'b0, r_x[i]} + (COORD_W+1)'(OBST_W)) > (COORD_W+1)'(DINO_X));
    end
  end

  assign o_valid = r_valid;

endmodule

// File: rtl/rex_game_core.sv
// Rex-Runner game controller: key sync, game FSM, tick divider, jump,
// score/speed ramp and LFSR; obstacle slots live in rex_obst_slots.
module rex_game_core
  import rex_game_pkg::*;
#(
  parameter int unsigned N_OBST       = 3,
  parameter int unsigned COORD_W      = 16,
  parameter int unsigned SCORE_W      = 16,
  parameter int unsigned TICK_DIV     = 50,
  parameter int unsigned SPAWN_X      = 232,
  parameter int unsigned DINO_X       = 16,
  parameter int unsigned DINO_W       = 16,
  parameter int unsigned OBST_W       = 16,
  parameter int unsigned OBST_H       = 26,
  parameter int unsigned SPEED_INIT   = 8,
  parameter int unsigned SPEED_MAX    = 12,
  parameter int unsigned SPEED_UP_PTS = 256,
  parameter int unsigned GAP_MIN      = 24,
  parameter int unsigned GAP_MASK     = 15,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_up,
  input  logic                      in_pause,
  output logic [COORD_W-1:0]        rex_y,
  output logic [N_OBST*COORD_W-1:0] obstacle_x,
  output logic [N_OBST-1:0]         obst_valid,
  output logic [1:0]                state,
  output logic [SCORE_W-1:0]        score,
  output logic [3:0]                speed,
  output logic                      hit
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  game_state_t        r_state, w_state_nx;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic [3:0]         r_jidx;
  logic [COORD_W-1:0] r_rex_y;
  logic [SCORE_W-1:0] r_score, w_score_inc;
  logic [3:0]         r_speed;
  logic               r_hit;
  logic [15:0]        r_lfsr;
  logic [1:0]         r_up_sync, r_pause_sync;
  logic               r_up_prev, r_pause_prev;
  logic               w_up_edge, w_pause_edge, w_tick, w_collide, w_step;
  logic               w_start, w_slot_clear, w_speed_bump;
  logic [N_OBST-1:0]  w_overlap;

  always_comb begin
    w_up_edge    = r_up_sync[1] & ~r_up_prev;
    w_pause_edge = r_pause_sync[1] & ~r_pause_prev;
    w_tick       = (r_state == ST_RUN) && (r_tick_cnt == CNT_W'(TICK_DIV - 1));
    w_collide    = (r_state == ST_RUN) && (|w_overlap) && (r_rex_y < COORD_W'(OBST_H));
    w_step       = w_tick && !w_collide;
    w_start      = (r_state == ST_IDLE) && w_up_edge;
    w_slot_clear = w_up_edge && ((r_state == ST_IDLE) || (r_state == ST_OVER));
    w_score_inc  = r_score + 1'b1;
    w_speed_bump = (r_score != '1) && ((w_score_inc % SCORE_W'(SPEED_UP_PTS)) == '0)
                && (r_speed < 4'(SPEED_MAX));
    w_state_nx   = r_state;
    case (r_state)
      ST_IDLE:  if (w_up_edge)    w_state_nx = ST_RUN;
      ST_RUN:   if (w_collide)    w_state_nx = ST_OVER;
                else if (w_pause_edge) w_state_nx = ST_PAUSE;
      ST_PAUSE: if (w_pause_edge) w_state_nx = ST_RUN;
      ST_OVER:  if (w_up_edge)    w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_tick_cnt   <= '0;
      r_jidx       <= '0;
      r_rex_y      <= '0;
      r_score      <= '0;
      r_speed      <= 4'(SPEED_INIT);
      r_hit        <= 1'b0;
      r_lfsr       <= LFSR_SEED;
      r_up_sync    <= '0;
      r_pause_sync <= '0;
      r_up_prev    <= 1'b0;
      r_pause_prev <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      r_up_sync    <= {r_up_sync[0], in_up};
      r_pause_sync <= {r_pause_sync[0], in_pause};
      r_up_prev    <= r_up_sync[1];
      r_pause_prev <= r_pause_sync[1];
      r_state      <= w_state_nx;
      r_hit        <= w_collide;
      if (w_start) begin
        r_tick_cnt <= '0;
        r_score    <= '0;
        r_speed    <= 4'(SPEED_INIT);
        r_jidx     <= '0;
        r_rex_y    <= '0;
      end else if ((r_state == ST_OVER) && w_up_edge) begin
        r_jidx  <= '0;
        r_rex_y <= '0;
      end else if ((r_state == ST_RUN) && !w_collide) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        if (w_tick) begin
          if (r_score != '1) r_score <= w_score_inc;
          if (w_speed_bump)  r_speed <= r_speed + 4'd1;
        end
        // jidx==0 is grounded; 1..JUMP_LEN selects the next table height to apply.
        if (r_jidx != '0) begin
          if (w_tick) begin
            r_rex_y <= COORD_W'(jump_y(3'(r_jidx - 4'd1)));
            r_jidx  <= (r_jidx == 4'(JUMP_LEN)) ? '0 : r_jidx + 4'd1;
          end
        end else if (w_up_edge) begin
          r_jidx <= 4'd1;
        end
      end
    end
  end

  rex_obst_slots #(
    .N_OBST   (N_OBST),
    .COORD_W  (COORD_W),
    .SPAWN_X  (SPAWN_X),
    .DINO_X   (DINO_X),
    .DINO_W   (DINO_W),
    .OBST_W   (OBST_W),
    .GAP_MIN  (GAP_MIN),
    .GAP_MASK (GAP_MASK)
  ) u_slots (
    .clk       (clk),
    .rstn      (rstn),
    .i_clear   (w_slot_clear),
    .i_step    (w_step),
    .i_speed   (r_speed),
    .i_rand    (r_lfsr),
    .o_x       (obstacle_x),
    .o_valid   (obst_valid),
    .o_overlap (w_overlap)
  );

  assign rex_y = r_rex_y;
  assign state = r_state;
  assign score = r_score;
  assign speed = r_speed;
  assign hit   = r_hit;

endmodule

// File: tb/tb_rex_game_core.sv
// Directed bench for rex_game_core: start, jump profile, pause, obstacle
// spawn/clear/hit, reset mid-jump, and speed ramp on a second instance.
module tb_rex_game_core;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_up = 1'b0, in_pause = 1'b0;
  logic        in_up2 = 1'b0, in_pause2 = 1'b0;
  logic [15:0] rex_y, rex_y2, score, score2;
  logic [47:0] obst_x, obst_x2;
  logic [2:0]  obst_valid, obst_valid2;
  logic [1:0]  state, state2;
  logic [3:0]  speed, speed2;
  logic        hit, hit2;

  int n_vec = 0;
  int n_err = 0;
  int hit_cnt = 0;
  int jtbl [8] = '{15, 27, 34, 36, 34, 27, 15, 0};

  always #5 clk = ~clk;

  always @(posedge clk) if (hit) hit_cnt++;

  rex_game_core #(.TICK_DIV(4)) dut (
    .clk(clk), .rstn(rstn), .in_up(in_up), .in_pause(in_pause),
    .rex_y(rex_y), .obstacle_x(obst_x), .obst_valid(obst_valid), .state(state),
    .score(score), .speed(speed), .hit(hit)
  );

  rex_game_core #(.TICK_DIV(4), .SPEED_UP_PTS(16), .GAP_MIN(200)) dut2 (
    .clk(clk), .rstn(rstn), .in_up(in_up2), .in_pause(in_pause2),
    .rex_y(rex_y2), .obstacle_x(obst_x2), .obst_valid(obst_valid2), .state(state2),
    .score(score2), .speed(speed2), .hit(hit2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_up();
    in_up = 1'b1;
    @(negedge clk);
    in_up = 1'b0;
  endtask

  task automatic press_pause();
    in_pause = 1'b1;
    @(negedge clk);
    in_pause = 1'b0;
  endtask

  task automatic wait_score(input int target);
    int n = 0;
    while (int'(score) != target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_score_%0d", target), score, target);
  endtask

  task automatic wait_score2(input int target);
    int n = 0;
    while (int'(score2) != target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_score2_%0d", target), score2, target);
  endtask

  function automatic int sx(input int i);
    return int'(obst_x[i*16 +: 16]);
  endfunction

  function automatic int has_x24();
    int f = 0;
    for (int i = 0; i < 3; i++) if (obst_valid[i] && sx(i) == 24) f = 1;
    return f;
  endfunction

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_state"}, state, 0);
    check({pfx, "_rex_y"}, rex_y, 0);
    check({pfx, "_obst_x"}, obst_x, 0);
    check({pfx, "_valid"}, obst_valid, 0);
    check({pfx, "_score"}, score, 0);
    check({pfx, "_speed"}, speed, 8);
    check({pfx, "_hit"}, hit, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sc_h, y_h;
    logic [47:0] x_h;
    int n;
    int tgt [7] = '{15, 16, 32, 48, 64, 80, 96};
    int spd [7] = '{8, 9, 10, 11, 12, 12, 12};

    step(3);
    check_reset_vals("reset");
    rstn = 1'b1;
    step(2);

    // Start: edge acts on the third clock after the key rises.
    in_up = 1'b1;
    step(2);
    check("start_not_yet", state, 0);
    step(1);
    check("start_run", state, 1);
    check("start_rex_y", rex_y, 0);
    check("start_score", score, 0);
    check("start_valid", obst_valid, 0);
    check("start_speed", speed, 8);
    in_up = 1'b0;
    step(2);

    // Jump profile, with a mid-air press that must be ignored.
    wait_score(1);
    press_up();
    for (int k = 0; k < 8; k++) begin
      wait_score(2 + k);
      check($sformatf("jump_y_%0d", k), rex_y, jtbl[k]);
      if (k == 2) press_up();
    end
    wait_score(10);
    check("jump_grounded", rex_y, 0);

    // Pause mid-jump.
    wait_score(12);
    press_up();
    wait_score(15);
    check("pj_y_before", rex_y, 34);
    press_pause();
    step(2);
    check("pause_state", state, 2);
    sc_h = score; y_h = rex_y; x_h = obst_x;
    press_up();
    step(40);
    check("pause_state_hold", state, 2);
    check("pause_score_hold", score, sc_h);
    check("pause_y_hold", rex_y, y_h);
    check("pause_x_hold", obst_x, x_h);
    press_pause();
    step(2);
    check("unpause_state", state, 1);
    check("unpause_y", rex_y, 34);
    for (int k = 3; k < 8; k++) begin
      wait_score(13 + k);
      check($sformatf("resume_y_%0d", k), rex_y, jtbl[k]);
    end

    // First spawn after GAP_MIN ticks.
    wait_score(24);
    check("gap_no_spawn", obst_valid, 0);
    wait_score(25);
    check("spawn_valid", obst_valid, 3'b001);
    check("spawn_x", sx(0), 232);
    wait_score(26);
    check("move_x", sx(0), 224);

    // Jump over the first obstacle.
    wait_score(49);
    press_up();
    wait_score(51);
    check("over_x24", sx(0), 24);
    check("over_y", rex_y, 27);
    check("over_state", state, 1);
    wait_score(53);
    check("over_y_peak", rex_y, 36);
    check("over_x8", sx(0), 8);
    wait_score(54);
    check("over_x0", sx(0), 0);
    wait_score(55);
    check("invalidate", obst_valid[0], 0);
    wait_score(56);
    check("survive_state", state, 1);
    check("survive_hits", hit_cnt, 0);

    // No jump: next obstacle must hit at x=24.
    n = 0;
    while (state != 2'd3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("hit_state", state, 3);
    check("hit_pulse_hi", hit, 1);
    check("hit_at_x24", has_x24(), 1);
    check("hit_y", rex_y, 0);
    sc_h = score; x_h = obst_x;
    step(1);
    check("hit_pulse_lo", hit, 0);
    step(20);
    check("over_hold_state", state, 3);
    check("over_hold_score", score, sc_h);
    check("over_hold_x", obst_x, x_h);
    check("hit_count", hit_cnt, 1);

    // OVER -> IDLE.
    press_up();
    step(2);
    check("idle_state", state, 0);
    check("idle_valid", obst_valid, 0);
    check("idle_y", rex_y, 0);

    // Reset mid-jump with a key edge in flight.
    press_up();
    step(2);
    check("rerun_state", state, 1);
    wait_score(1);
    press_up();
    wait_score(3);
    check("rerun_y", rex_y, 27);
    in_up = 1'b1;
    step(1);
    in_up = 1'b0;
    rstn = 1'b0;
    step(1);
    check_reset_vals("midrst");
    rstn = 1'b1;
    step(6);
    check("no_pending_edge", state, 0);

    // Speed ramp on second instance.
    in_up2 = 1'b1;
    step(1);
    in_up2 = 1'b0;
    step(2);
    check("d2_run", state2, 1);
    for (int i = 0; i < 7; i++) begin
      wait_score2(tgt[i]);
      check($sformatf("speed_at_%0d", tgt[i]), speed2, spd[i]);
    end
    check("d2_valid", obst_valid2, 0);
    check("d2_x", obst_x2, 0);
    check("d2_hit", hit2, 0);
    check("d2_y", rex_y2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
